// File: rtl/gardner_pkg.sv
// Shared types and helpers for the Gardner timing-recovery slice.
// Constants derive from NCO width and log2 samples-per-symbol.
package gardner_pkg;

  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCKED
  } lock_state_t;

  function automatic longint nom_f(int nco_w, int sps_log2);
    return longint'(1) << (nco_w - sps_log2);
  endfunction

  function automatic longint inc_lo_f(int nco_w, int sps_log2);
    return nom_f(nco_w, sps_log2) / 2;
  endfunction

  function automatic longint inc_hi_f(int nco_w, int sps_log2);
    return nom_f(nco_w, sps_log2) * 2;
  endfunction

  function automatic longint integ_lim_f(int nco_w, int sps_log2);
    return nom_f(nco_w, sps_log2) / 8;
  endfunction

  function automatic longint sat_f(longint v, longint lo, longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Most negative code folds onto the largest positive one.
  function automatic longint abs_f(longint v, int w);
    longint m;
    m = (longint'(1) << (w - 1)) - 1;
    if (v >= 0) return v;
    return (-v > m) ? m : -v;
  endfunction

endpackage

// File: rtl/gardner_timing_recovery_if.sv
// Sample-in / symbol-out bundle for the Gardner timing recovery.
// slave = the recovery block, master = whoever feeds it.
interface gardner_timing_recovery_if #(
  parameter int WIDTH = 16,
  parameter int NCO_W = 32
);
  logic                    in_valid;
  logic signed [WIDTH-1:0] I_in;
  logic signed [WIDTH-1:0] Q_in;
  logic [3:0]              kp_shift;
  logic [3:0]              ki_shift;
  logic                    loop_en;
  logic signed [WIDTH-1:0] I_sym;
  logic signed [WIDTH-1:0] Q_sym;
  logic                    sym_valid;
  logic signed [WIDTH-1:0] error_n;
  logic [NCO_W-1:0]        increment;
  logic                    locked;

  modport master (
    output in_valid, I_in, Q_in,
    output kp_shift, ki_shift, loop_en,
    input  I_sym, Q_sym, sym_valid,
    input  error_n, increment, locked
  );

  modport slave (
    input  in_valid, I_in, Q_in,
    input  kp_shift, ki_shift, loop_en,
    output I_sym, Q_sym, sym_valid,
    output error_n, increment, locked
  );
endinterface

// File: rtl/gardner_lock_detect.sv
// Lock detector: counts consecutive good/bad symbol errors.
// SEARCH until the loop closes, then TRACK <-> LOCKED by hysteresis.
module gardner_lock_detect
  import gardner_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int LOCK_THRESH  = 1024,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] error_n,
  input  logic                    strobe,
  input  logic                    loop_en,
  output lock_state_t             state,
  output logic                    locked
);
  localparam int CMAX = (LOCK_COUNT > UNLOCK_COUNT) ?
                        LOCK_COUNT : UNLOCK_COUNT;
  localparam int CW = $clog2(CMAX + 1);

  logic [CW-1:0] cnt;
  logic          good;

  assign good = abs_f(longint'(error_n), WIDTH) <
                longint'(LOCK_THRESH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SEARCH;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (!loop_en) begin
      state  <= SEARCH;
      cnt    <= '0;
      locked <= 1'b0;
    end else begin
      unique case (state)
        SEARCH: begin
          state <= TRACK;
          cnt   <= '0;
        end
        TRACK: if (strobe) begin
          if (!good) begin
            cnt <= '0;
          end else if (cnt == CW'(LOCK_COUNT - 1)) begin
            state  <= LOCKED;
            locked <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOCKED: if (strobe) begin
          if (good) begin
            cnt <= '0;
          end else if (cnt == CW'(UNLOCK_COUNT - 1)) begin
            state  <= TRACK;
            locked <= 1'b0;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= SEARCH;
          cnt    <= '0;
          locked <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/gardner_timing_recovery.sv
// Gardner symbol-timing recovery: TED, PI loop filter, NCO, lock detect.
// One symbol per NCO carry; error/increment follow 1 and 2 clocks later.
module gardner_timing_recovery
  import gardner_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int NCO_W        = 32,
  parameter int SPS_LOG2     = 5,
  parameter int LOCK_THRESH  = 1024,
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 16
) (
  input logic clk_32M768,
  input logic rst_32M768,
  gardner_timing_recovery_if.slave bus
);
  localparam longint NOM_L = nom_f(NCO_W, SPS_LOG2);
  localparam longint LIM_L = integ_lim_f(NCO_W, SPS_LOG2);
  localparam longint INC_LO = inc_lo_f(NCO_W, SPS_LOG2);
  localparam longint INC_HI = inc_hi_f(NCO_W, SPS_LOG2);
  localparam longint E_MAX = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint E_MIN = -(longint'(1) << (WIDTH - 1));
  localparam logic [NCO_W-1:0] NOM = NCO_W'(NOM_L);
  localparam int EW = 2 * WIDTH + 2;

  typedef logic signed [WIDTH-1:0] smp_t;

  smp_t i_sym, q_sym, i_prev, q_prev, i_mid, q_mid, err;
  logic [NCO_W-1:0]        phase, inc;
  logic signed [NCO_W-1:0] integ;
  logic                    stb_d1, stb_d2;
  lock_state_t             state;
  logic                    locked;

  logic [NCO_W:0]          phase_sum;
  logic                    sym_stb, mid_stb;
  logic signed [WIDTH:0]   di, dq;
  logic signed [EW-1:0]    e_full;
  smp_t                    err_sat;
  longint                  kp_term, ki_term, integ_new, inc_new;

  assign phase_sum = {1'b0, phase} + {1'b0, inc};
  assign sym_stb = bus.in_valid & phase_sum[NCO_W];
  assign mid_stb = bus.in_valid & ~phase[NCO_W-1] &
                   phase_sum[NCO_W-1];

  // i_sym is the current symbol, i_prev the one before it.
  assign di = {i_prev[WIDTH-1], i_prev} - {i_sym[WIDTH-1], i_sym};
  assign dq = {q_prev[WIDTH-1], q_prev} - {q_sym[WIDTH-1], q_sym};
  assign e_full = EW'(i_mid) * EW'(di) + EW'(q_mid) * EW'(dq);

  always_comb begin
    err_sat = smp_t'(sat_f(longint'(e_full >>> (WIDTH - 1)),
                           E_MIN, E_MAX));
    kp_term = longint'(err) >>> bus.kp_shift;
    ki_term = longint'(err) >>> bus.ki_shift;
    integ_new = sat_f(longint'(integ) + ki_term, -LIM_L, LIM_L);
    inc_new = sat_f(NOM_L + kp_term + integ_new, INC_LO, INC_HI);
  end

  always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
    if (rst_32M768) begin
      phase  <= '0;
      inc    <= NOM;
      integ  <= '0;
      i_sym  <= '0;
      q_sym  <= '0;
      i_prev <= '0;
      q_prev <= '0;
      i_mid  <= '0;
      q_mid  <= '0;
      err    <= '0;
      stb_d1 <= 1'b0;
      stb_d2 <= 1'b0;
    end else begin
      stb_d1 <= sym_stb;
      stb_d2 <= stb_d1;
      if (bus.in_valid) phase <= phase_sum[NCO_W-1:0];
      if (mid_stb) begin
        i_mid <= bus.I_in;
        q_mid <= bus.Q_in;
      end
      if (sym_stb) begin
        i_sym  <= bus.I_in;
        q_sym  <= bus.Q_in;
        i_prev <= i_sym;
        q_prev <= q_sym;
      end
      if (stb_d1) err <= err_sat;
      if (!bus.loop_en || state == SEARCH) begin
        integ <= '0;
        inc   <= NOM;
      end else if (stb_d2) begin
        integ <= NCO_W'(integ_new);
        inc   <= NCO_W'(inc_new);
      end
    end
  end

  gardner_lock_detect #(
    .WIDTH       (WIDTH),
    .LOCK_THRESH (LOCK_THRESH),
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) u_lock (
    .clk    (clk_32M768),
    .rst    (rst_32M768),
    .error_n(err),
    .strobe (stb_d2),
    .loop_en(bus.loop_en),
    .state  (state),
    .locked (locked)
  );

  assign bus.I_sym     = i_sym;
  assign bus.Q_sym     = q_sym;
  assign bus.sym_valid = stb_d1;
  assign bus.error_n   = err;
  assign bus.increment = inc;
  assign bus.locked    = locked;
endmodule

// File: tb/tb_gardner_timing_recovery.sv
// Directed bench for gardner_timing_recovery (default parameters).
// Symbols are driven on a fixed 32-sample grid: mid at 16, strobe at 32.
module tb_gardner_timing_recovery;
  localparam longint NOM = 134217728;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;
  int   first, second, nsym, s, lastcur;

  always #15 clk = ~clk;

  gardner_timing_recovery_if #(.WIDTH(16), .NCO_W(32)) bus ();

  gardner_timing_recovery dut (
    .clk_32M768(clk),
    .rst_32M768(rst),
    .bus       (bus)
  );

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic drive_sym(input int cur, input int mid,
                           input bit qsame);
    logic signed [15:0] v;
    for (int j = 1; j <= 32; j++) begin
      v = (j == 16) ? 16'(mid) : (j == 32) ? 16'(cur) : 16'sd0;
      bus.in_valid = 1'b1;
      bus.I_in = v;
      bus.Q_in = qsame ? v : 16'sd0;
      step();
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_I_sym"}, bus.I_sym, 0);
    chk({tag, "_Q_sym"}, bus.Q_sym, 0);
    chk({tag, "_err"}, bus.error_n, 0);
    chk({tag, "_valid"}, bus.sym_valid, 0);
    chk({tag, "_locked"}, bus.locked, 0);
    chk({tag, "_inc"}, bus.increment, NOM);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.I_in = '0;
    bus.Q_in = '0;
    bus.kp_shift = 4'd0;
    bus.ki_shift = 4'd4;
    bus.loop_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("in_rst");
    rst = 1'b0;
    step();
    step();
    chk_reset("post_rst");

    // open loop, continuous samples
    bus.in_valid = 1'b1;
    first = 0;
    second = 0;
    for (int c = 1; c <= 100 && second == 0; c++) begin
      @(negedge clk);
      if (bus.sym_valid) begin
        if (first == 0) first = c;
        else second = c;
      end
    end
    chk("first_sym_clock", first, 33);
    chk("sym_spacing", second - first, 32);

    // open loop, in_valid every other cycle
    first = 0;
    second = 0;
    for (int c = 1; c <= 300 && second == 0; c++) begin
      @(negedge clk);
      bus.in_valid = ~bus.in_valid;
      if (bus.sym_valid) begin
        if (first == 0) first = c;
        else second = c;
      end
    end
    chk("toggle_spacing", second - first, 64);

    bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    // error and PI update
    bus.loop_en = 1'b1;
    drive_sym(16384, 0, 0);
    chk("symA_valid", bus.sym_valid, 1);
    chk("symA_I", bus.I_sym, 16384);
    drive_sym(-16384, 8192, 0);
    chk("symB_I", bus.I_sym, -16384);
    idle(1);
    chk("symB_err", bus.error_n, 8192);
    chk("pulse_width", bus.sym_valid, 0);
    idle(1);
    chk("pi_inc", bus.increment, 134226432);
    bus.loop_en = 1'b0;
    idle(1);
    chk("drop_inc_nom", bus.increment, NOM);

    // positive error saturation
    bus.kp_shift = 4'd15;
    bus.ki_shift = 4'd15;
    drive_sym(-32768, 0, 1);
    drive_sym(32767, -32768, 1);
    chk("satD_Q", bus.Q_sym, 32767);
    idle(1);
    chk("err_sat_pos", bus.error_n, 32767);

    // integrator floor: every symbol flips sign, error stays -32768
    bus.loop_en = 1'b1;
    bus.ki_shift = 4'd0;
    bus.I_in = -16'sd32768;
    bus.Q_in = -16'sd32768;
    bus.in_valid = 1'b1;
    nsym = 0;
    for (int c = 0; c < 40000 && nsym < 600; c++) begin
      @(negedge clk);
      if (bus.sym_valid) begin
        nsym++;
        bus.I_in = (bus.I_in == 16'sh7fff) ? -16'sd32768 : 16'sd32767;
        bus.Q_in = bus.I_in;
      end
    end
    chk("floor_syms", nsym, 600);
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("integ_floor_inc", bus.increment, 117440511);
    chk("floor_err", bus.error_n, -32768);
    chk("floor_unlocked", bus.locked, 0);

    // lock / unlock hysteresis
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    bus.loop_en = 1'b1;
    bus.kp_shift = 4'd15;
    bus.ki_shift = 4'd15;
    s = 16384;
    repeat (63) begin
      drive_sym(s, 0, 0);
      s = -s;
    end
    idle(2);
    chk("lock_after_63", bus.locked, 0);
    drive_sym(s, 0, 0);
    s = -s;
    idle(2);
    chk("lock_after_64", bus.locked, 1);
    repeat (15) begin
      drive_sym(s, (s > 0) ? -1024 : 1024, 0);
      s = -s;
    end
    idle(2);
    chk("bad_15_locked", bus.locked, 1);
    chk("err_1024", bus.error_n, 1024);
    drive_sym(s, (s > 0) ? -1024 : 1024, 0);
    s = -s;
    idle(2);
    chk("bad_16_unlocked", bus.locked, 0);
    repeat (63) begin
      drive_sym(s, (s > 0) ? -1023 : 1023, 0);
      s = -s;
    end
    idle(2);
    chk("err_1023", bus.error_n, 1023);
    chk("relock_63", bus.locked, 0);
    drive_sym(s, (s > 0) ? -1023 : 1023, 0);
    s = -s;
    idle(2);
    chk("relock_64", bus.locked, 1);

    // disruption: loop_en drop, then async reset
    bus.kp_shift = 4'd0;
    lastcur = s;
    drive_sym(s, (s > 0) ? -8192 : 8192, 0);
    s = -s;
    idle(2);
    chk("locked_inc", bus.increment, NOM + 8192);
    chk("locked_hold", bus.locked, 1);
    bus.loop_en = 1'b0;
    bus.in_valid = 1'b1;
    bus.I_in = 16'sd1000;
    step();
    chk("drop_locked", bus.locked, 0);
    chk("drop_inc", bus.increment, NOM);
    bus.loop_en = 1'b1;
    chk("pre_rst_err", bus.error_n, 8192);
    chk("pre_rst_I", bus.I_sym, lastcur);
    @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_reset("async_rst");
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/gardner_timing_recovery.md
Name: gardner_timing_recovery

Overview:
Parametrised next-generation Gardner symbol-timing recovery for the I/Q baseband path, running at 32.768 MHz. It integrates the Gardner timing-error detector, a proportional-integral loop filter, a phase-accumulator NCO and a lock detector into one clocked block. Input is the interpolated/smoothed I/Q sample stream. Output is one I/Q symbol per recovered symbol strobe, with valid, error, increment and lock status.

Parameters:
WIDTH, 16, signed I/Q sample and error width
NCO_W, 32, NCO phase accumulator width
SPS_LOG2, 5, log2 of nominal samples per symbol; must be ≥2 (32 gives 1.024 MBd)
LOCK_THRESH, 1024, |error_n| below this counts as a good symbol
LOCK_COUNT, 64, consecutive good symbols needed to declare lock
UNLOCK_COUNT, 16, consecutive bad symbols needed to drop lock

Ports:
clk_32M768  in  1  system clock
rst_32M768  in  1  asynchronous, active-high reset
in_valid  in  1  input sample qualifier; block advances only when high
I_in  in  WIDTH  signed I sample
Q_in  in  WIDTH  signed Q sample
kp_shift  in  4  proportional right-shift
ki_shift  in  4  integral right-shift
loop_en  in  1  closes the timing loop
I_sym  out  WIDTH  recovered I symbol, held between strobes
Q_sym  out  WIDTH  recovered Q symbol, held between strobes
sym_valid  out  1  one-cycle pulse per new symbol
error_n  out  WIDTH  last timing error, saturated
increment  out  NCO_W  current NCO step
locked  out  1  lock indication

Behaviour:
- Reset values: I_sym, Q_sym, error_n = 0; sym_valid = 0; locked = 0; increment = NOM, where NOM = 2^(NCO_W−SPS_LOG2). Reset also clears phase, integrator, prev/mid registers and counters, and puts the FSM in SEARCH. Reset is asynchronous and honoured mid-operation.
- All state is frozen on cycles where in_valid = 0.
- NCO:
  - On each valid cycle, phase <= phase + increment (mod 2^NCO_W).
  - Carry-out = symbol strobe.
  - Phase MSB transition 0→1 = mid strobe.
  - increment is clamped to [NOM/2, 2·NOM], so at most one strobe occurs per step.
- Mid strobe: capture I_in/Q_in into I_mid/Q_mid.
- Symbol strobe, at cycle S:
  - I_sym/Q_sym <= I_in/Q_in at S+1, with sym_valid = 1 for exactly that one cycle.
  - prev <= cur.
  - The first symbol after reset uses prev = 0.
- Error:
  - e = I_mid·(I_prev−I_cur) + Q_mid·(Q_prev−Q_cur), computed at full precision (2·WIDTH+2 bits, signed).
  - error_n = saturate(e >>> (WIDTH−1)) to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - error_n is registered at S+2.
- Loop filter, at S+3, only in TRACK or LOCKED:
  - integ <= sat(integ + sext(error_n >>> ki_shift)), limited to ±NOM/8.
  - increment <= clamp(NOM + sext(error_n >>> kp_shift) + integ_new).
- FSM, evaluated at S+3:
  - SEARCH: increment = NOM, integ = 0. loop_en = 1 → TRACK.
  - TRACK: good symbol → cnt++; bad symbol → cnt = 0. cnt reaching LOCK_COUNT → LOCKED (locked = 1), cnt = 0.
  - LOCKED: bad symbol → cnt++; good symbol → cnt = 0. cnt reaching UNLOCK_COUNT → TRACK (locked = 0), cnt = 0.
  - loop_en = 0 in any state → SEARCH on the next clock: locked = 0, integ = 0, increment = NOM. Phase is not reset.
- |−2^(WIDTH−1)| is treated as 2^(WIDTH−1)−1 for the threshold compare.
- A new strobe arriving while the S+1..S+3 pipeline is busy is impossible, since the minimum symbol spacing is SPS/2 ≥ 2 valid cycles. Pipeline stages advance on clock, not in_valid.

Decomposition:
- Shared package gardner_pkg holds:
  - lock-state encoding (SEARCH/TRACK/LOCKED);
  - NOM and clamp-limit constants as functions of NCO_W/SPS_LOG2;
  - signed saturate and abs helpers.
- One sub-module, gardner_lock_detect: takes error_n, a strobe and loop_en; produces state and locked.
- The NCO, TED and loop filter stay in the top level.

Test Plan:
- Reset check: during reset and after release, all outputs equal their reset values, with increment = 134217728 (2^27 with defaults).
- Open loop: loop_en = 0, in_valid held high → first sym_valid on clock 33 (phase wraps on the 32nd valid sample), then every 32 clocks. With in_valid toggling every cycle, the spacing becomes every 64 clocks.
- Error computation: I_prev = 16384, I_cur = −16384, I_mid = 8192, Q = 0, kp_shift = 0, ki_shift = 4 → error_n = 8192, then increment = 134217728 + 8192 + 512 = 134226432.
- Saturation: I_mid = −32768, I_prev = −32768, I_cur = 32767, Q same → error_n = 32767. Integrator stops at ±16777216.
- Lock: aligned ±16384 symbols with zero mid samples, loop_en = 1 → locked rises after 64 symbols. Then 16 symbols with |error_n| ≥ 1024 → locked falls.
- Mid-run disruption: dropping loop_en gives locked = 0 and increment = NOM on the next clock. Asserting rst_32M768 mid-symbol clears all outputs immediately, without waiting for a clock edge.
